ssd_scan_driver: RTL and testbench
==================================

Name: ssd_scan_driver

Overview:
- Consumes the 13-bit debug value the CPU drives on its seven-segment select path and displays it as a 4-digit decimal number on a multiplexed common-anode display.
- Runs a sequential double-dabble binary-to-BCD converter, which re-triggers whenever the input value changes.
- Holds the converted BCD in a register and time-multiplexes the four digits using a free-running refresh counter.
- Blanks leading zeros and registers every display output.

Parameters:
- REFRESH_BITS, 18: width of the refresh counter. The top 2 bits select the digit, so each digit is lit for 2^(REFRESH_BITS-2) cycles. Benches use 4.
- BLANK_LEADING, 1: 1 blanks leading zero digits; digit 0 is never blanked.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock domain, reset is asynchronous and active-low
- num_i  in  13  binary value to display (0..8191)
- an_o  out  4  digit anodes, active-low, bit k = digit k (digit 0 = least significant)
- seg_o  out  7  segment cathodes {g,f,e,d,c,b,a}, active-low
- dp_o  out  1  decimal point, active-low, held at 1 (off)
- bcd_o  out  16  current displayed BCD value {d3,d2,d1,d0}
- busy_o  out  1  high while a conversion is in progress

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - an_o=4'hF, seg_o=7'h7F, dp_o=1, bcd_o=0, busy_o=0
  - refresh counter=0, last_num_q=0, FSM=IDLE
- Converter FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If num_i != last_num_q: latch num_i into shift_q, clear the work BCD, set bit_cnt=13, set busy_o=1, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, once per cycle:
  - For each BCD nibble >= 5, add 3.
  - Then shift {bcd_work, shift_q} left by 1 and decrement bit_cnt.
  - When bit_cnt reaches 1 on this shift, go to DONE.
- DONE: bcd_o <= bcd_work, last_num_q <= captured value, busy_o=0, go to IDLE.
- Latency: if num_i changes at edge N (sampled at N+1), busy_o is high from N+1, bcd_o updates at edge N+15, and busy_o drops at N+15. Total 15 cycles.
- num_i changes during SHIFT are ignored until DONE. The next IDLE compares again and re-converts to the latest value; intermediate values are never shown.
- bcd_o holds its old value during a conversion, so the display never shows partial results.
- Max input 8191 gives 0x8191; d3 never exceeds 8. Nibble add-3 arithmetic is 4-bit; the work register is 16 bits.
- Refresh counter: free-running, wraps at 2^REFRESH_BITS - 1 to 0. idx = cnt[REFRESH_BITS-1 : REFRESH_BITS-2].
- Output stage (registered, one cycle after idx):
  - an_o = ~(4'b1 << idx)
  - seg_o = decode(bcd_o nibble idx)
- Blanking, when BLANK_LEADING=1: digit k (k>0) is blanked if it and all higher digits are zero. A blanked digit drives seg_o=7'h7F with its anode still active.
- Inner zeros are never blanked.
- Segment codes, active-low gfedcba:
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - nibbles >9 (unreachable) give 7F
- Reset mid-conversion: the FSM goes to IDLE and work registers clear. After release, if num_i != 0, a new conversion starts on the first sampling edge.

Decomposition:
- Shared package:
  - NUM_W=13, NUM_DIGITS=4
  - converter state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2)
  - segment code constants SEG_0..SEG_9, SEG_BLANK=7'h7F
- Sub-module bin2bcd_seq holds the FSM and shift logic.
  - Ports: clk, rst, bin_i[12:0], bcd_o[15:0], busy_o.
- The top level holds the refresh counter, digit mux, blanking and output registers.

Test Plan:
1. Assert rst with num_i=0, release -> an_o=F, seg_o=7F during reset. Afterwards busy_o stays 0, bcd_o=0x0000, digit 0 shows 40, digits 1-3 show 7F.
2. REFRESH_BITS=4, num_i=1234 -> busy_o high 14 cycles, bcd_o=0x1234 at 15th edge. Scan shows an_o=E/seg 19, D/30, B/24, 7/79, each held 4 cycles.
3. num_i=8191 -> bcd_o=0x8191; with an_o=7, seg_o=00.
4. num_i=7 -> digit 0 seg 78, digits 1-3 seg 7F. num_i=1000 -> digits show 40,40,40,79 with no blanking.
5. num_i=1234, then 42 applied 5 cycles into SHIFT -> bcd_o=0x1234 first. Immediate re-conversion gives bcd_o=0x0042 15 cycles after DONE; digits 2-3 are blanked.
6. Assert rst during SHIFT of 999 -> outputs reset immediately. After release, conversion restarts and bcd_o=0x0999 after 15 cycles.

Source files
------------

// File: rtl/ssd_scan_driver_pkg.sv
// Shared types and constants for the seven-segment scan driver and its
// sequential binary-to-BCD converter.
package ssd_scan_driver_pkg;

  localparam int NUM_W      = 13;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam int CNT_W      = $clog2(NUM_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (v[4*k +: 4] >= 4'd5) r[4*k +: 4] = v[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Bus between the CPU debug path and the display driver: the value to show
// plus the physical display lines and converter status.
interface ssd_scan_driver_if;
  logic [ssd_scan_driver_pkg::NUM_W-1:0] num_i;
  logic [3:0]                            an_o;
  logic [6:0]                            seg_o;
  logic                                  dp_o;
  logic [ssd_scan_driver_pkg::BCD_W-1:0] bcd_o;
  logic                                  busy_o;

  modport master (output num_i, input an_o, seg_o, dp_o, bcd_o, busy_o);
  modport slave  (input num_i, output an_o, seg_o, dp_o, bcd_o, busy_o);
endinterface

// File: rtl/ssd_scan_driver_bin2bcd.sv
// Sequential double-dabble converter: one bit per cycle, re-triggered whenever
// the input differs from the last value converted.
module bin2bcd_seq
  import ssd_scan_driver_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_W-1:0] bin_i,
  output logic [BCD_W-1:0] bcd_o,
  output logic             busy_o
);

  conv_state_e      state_q, state_d;
  logic [NUM_W-1:0] last_num_q, cap_q, shift_q;
  logic [BCD_W-1:0] work_q, work_adj, bcd_q;
  logic [CNT_W-1:0] bit_cnt_q;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: next state defaults to the current state so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bin_i != last_num_q) state_d = SHIFT;
      SHIFT:   if (bit_cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != IDLE);
  end

  assign work_adj = bcd_add3(work_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_num_q <= '0;
      cap_q      <= '0;
      shift_q    <= '0;
      work_q     <= '0;
      bcd_q      <= '0;
      bit_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (state_d == SHIFT) begin
          cap_q     <= bin_i;
          shift_q   <= bin_i;
          work_q    <= '0;
          bit_cnt_q <= CNT_W'(NUM_W);
        end
        SHIFT: begin
          work_q    <= {work_adj[BCD_W-2:0], shift_q[NUM_W-1]};
          shift_q   <= {shift_q[NUM_W-2:0], 1'b0};
          bit_cnt_q <= bit_cnt_q - CNT_W'(1);
        end
        DONE: begin
          // Only a finished result reaches the display; inputs seen during
          // the conversion are picked up by the next IDLE comparison.
          bcd_q      <= work_q;
          last_num_q <= cap_q;
        end
        default: ;
      endcase
    end
  end

  assign bcd_o = bcd_q;

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed common-anode display driver: converts the debug value
// to BCD, scans the digits with a refresh counter and blanks leading zeros.
module ssd_scan_driver
  import ssd_scan_driver_pkg::*;
#(
  parameter int REFRESH_BITS  = 18,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  ssd_scan_driver_if.slave   bus
);

  logic [BCD_W-1:0]        bcd;
  logic                    busy;
  logic [REFRESH_BITS-1:0] cnt_q;
  logic [1:0]              idx;
  logic [3:0]              digit;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    lead;
  logic [3:0]              an_q;
  logic [6:0]              seg_q;

  bin2bcd_seq u_conv (
    .clk    (clk),
    .rst    (rst),
    .bin_i  (bus.num_i),
    .bcd_o  (bcd),
    .busy_o (busy)
  );

  assign idx   = cnt_q[REFRESH_BITS-1 -: 2];
  assign digit = bcd[{idx, 2'b00} +: 4];

  // A digit is blank when it and every more significant digit are zero;
  // digit 0 always shows so a zero value reads "0".
  always_comb begin
    blank = '0;
    lead  = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      lead     = lead && (bcd[4*k +: 4] == 4'd0);
      blank[k] = lead;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      an_q  <= 4'hF;
      seg_q <= SEG_BLANK;
    end else begin
      cnt_q <= cnt_q + REFRESH_BITS'(1);
      an_q  <= ~(4'b0001 << idx);
      seg_q <= (BLANK_LEADING && blank[idx]) ? SEG_BLANK : seg_decode(digit);
    end
  end

  assign bus.an_o   = an_q;
  assign bus.seg_o  = seg_q;
  assign bus.dp_o   = 1'b1;
  assign bus.bcd_o  = bcd;
  assign bus.busy_o = busy;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver: stimulus queues expected conversions
// and digit patterns, a monitor checks them as the DUT completes each one.
module tb_ssd_scan_driver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_active = 1'b0;

  typedef struct {
    bit              conv;
    logic [15:0]     bcd;
    logic [3:0][6:0] seg;
    bit              scan;
    int              start;
    int              gap;
  } exp_t;

  exp_t sb_q[$];

  ssd_scan_driver_if bus ();

  ssd_scan_driver #(.REFRESH_BITS(4), .BLANK_LEADING(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0][6:0] mk(input logic [6:0] s3, s2, s1, s0);
    return {s3, s2, s1, s0};
  endfunction

  // Observe 16 consecutive cycles: each anode must be lit 4 times with its code.
  task automatic scan_check(input exp_t e);
    int cnt[4];
    int k;
    for (int j = 0; j < 4; j++) cnt[j] = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (bus.an_o)
        4'hE:    k = 0;
        4'hD:    k = 1;
        4'hB:    k = 2;
        4'h7:    k = 3;
        default: k = -1;
      endcase
      if (k < 0) begin
        check("an_onehot", bus.an_o, 4'hE);
      end else begin
        check($sformatf("seg_d%0d", k), bus.seg_o, e.seg[k]);
        cnt[k]++;
      end
      check("dp_off", bus.dp_o, 1'b1);
      check("busy_idle", bus.busy_o, 1'b0);
    end
    for (int j = 0; j < 4; j++) check($sformatf("hold_d%0d", j), cnt[j], 4);
  endtask

  // Monitor: pops the scoreboard when a conversion finishes (busy falls) or,
  // for no-conversion entries, whenever the converter is idle.
  initial begin
    bit   busy_prev = 1'b0;
    int   busy_cnt  = 0;
    int   last_fall = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_prev = 1'b0;
        busy_cnt  = 0;
        continue;
      end
      if (bus.busy_o) busy_cnt++;
      if (busy_prev && !bus.busy_o) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: bcd %0h with empty scoreboard", bus.bcd_o);
        end else begin
          mon_active = 1'b1;
          e = sb_q.pop_front();
          check("entry_is_conv", e.conv, 1'b1);
          check("bcd", bus.bcd_o, e.bcd);
          check("busy_len", busy_cnt, 14);
          if (e.start >= 0) check("latency", cyc - e.start, 15);
          if (e.gap > 0) check("redo_gap", cyc - last_fall, e.gap);
          last_fall = cyc;
          if (e.scan) scan_check(e);
          mon_active = 1'b0;
        end
        busy_cnt = 0;
      end else if (!bus.busy_o && sb_q.size() > 0 && !sb_q[0].conv) begin
        mon_active = 1'b1;
        e = sb_q.pop_front();
        check("bcd_static", bus.bcd_o, e.bcd);
        if (e.scan) scan_check(e);
        mon_active = 1'b0;
      end
      busy_prev = bus.busy_o;
    end
  end

  task automatic push(input bit conv, input logic [15:0] bcd, input logic [3:0][6:0] seg,
                      input bit scan, input int start, input int gap);
    exp_t e;
    e.conv = conv; e.bcd = bcd; e.seg = seg; e.scan = scan; e.start = start; e.gap = gap;
    sb_q.push_back(e);
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while ((sb_q.size() != 0 || mon_active) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: %0d entries still pending", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!bus.busy_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy_rise"}, bus.busy_o, 1'b1);
  endtask

  task automatic apply(input logic [12:0] v, input logic [15:0] bcd,
                       input logic [3:0][6:0] seg, input string name);
    @(posedge clk);
    #1 bus.num_i = v;
    push(1'b1, bcd, seg, 1'b1, cyc, 0);
    wait_drained(name);
  endtask

  initial begin
    bus.num_i = '0;
    rst = 1'b0;

    // 1: reset state, then no conversion for a zero input
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_an", bus.an_o, 4'hF);
    check("rst_seg", bus.seg_o, 7'h7F);
    check("rst_dp", bus.dp_o, 1'b1);
    check("rst_bcd", bus.bcd_o, 16'h0000);
    check("rst_busy", bus.busy_o, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    push(1'b0, 16'h0000, mk(7'h7F, 7'h7F, 7'h7F, 7'h40), 1'b1, -1, 0);
    wait_drained("zero");

    // 2-4: conversions, scan order and blanking
    apply(13'd1234, 16'h1234, mk(7'h79, 7'h24, 7'h30, 7'h19), "n1234");
    apply(13'd8191, 16'h8191, mk(7'h00, 7'h79, 7'h10, 7'h79), "n8191");
    apply(13'd7,    16'h0007, mk(7'h7F, 7'h7F, 7'h7F, 7'h78), "n7");
    apply(13'd1000, 16'h1000, mk(7'h79, 7'h40, 7'h40, 7'h40), "n1000");

    // 5: input change during SHIFT is deferred, then re-converted
    @(posedge clk);
    #1 bus.num_i = 13'd1234;
    push(1'b1, 16'h1234, mk(7'h79, 7'h24, 7'h30, 7'h19), 1'b0, cyc, 0);
    wait_busy("mid");
    repeat (5) @(posedge clk);
    #1 bus.num_i = 13'd42;
    push(1'b1, 16'h0042, mk(7'h7F, 7'h7F, 7'h19, 7'h24), 1'b1, -1, 15);
    wait_drained("n42");

    // 6: reset in the middle of a conversion
    @(posedge clk);
    #1 bus.num_i = 13'd999;
    wait_busy("rst999");
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_an", bus.an_o, 4'hF);
    check("mid_rst_seg", bus.seg_o, 7'h7F);
    check("mid_rst_bcd", bus.bcd_o, 16'h0000);
    check("mid_rst_busy", bus.busy_o, 1'b0);
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    push(1'b1, 16'h0999, mk(7'h7F, 7'h10, 7'h10, 7'h10), 1'b1, cyc, 0);
    wait_drained("n999");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
